// File: rtl/i2c_slv_pkg.sv
// i2c_slave_rx shared types: FSM state encoding, widths,
// and the majority-vote helper used by the optional glitch filter.
package i2c_slv_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser, edge and START/STOP detect.
// I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter.
module i2c_line_sync
  import i2c_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;

  // idle bus is high, so reset to 1 to avoid false edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [2:0] scl_win;
  logic [2:0] sda_win;

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_win <= '1;
      sda_win <= '1;
    end else begin
      scl_win <= {scl_win[1:0], scl_sync[SYNC_STAGES-1]};
      sda_win <= {sda_win[1:0], sda_sync[SYNC_STAGES-1]};
    end
  end

  assign scl = maj3(scl_win);
  assign sda = maj3(sda_win);
`else
  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C target: address match, write receive, read serve.
// Optional glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_rx
  import i2c_slv_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_scl_in,
  input  logic              i2c_sda_in,
  output logic              sda_pull_low,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              rx_rw,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  logic scl_lvl;
  logic sda_lvl;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (i2c_scl_in),
    .sda_in   (i2c_sda_in),
    .scl      (scl_lvl),
    .sda      (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  state_t                 state;
  logic [DATA_W-1:0]      shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   byte_done;
  logic                   last_bit;
  logic                   fall_ok;
  logic [DATA_W-1:0]      byte_in;

  assign last_bit = (bit_cnt == BIT_CNT_W'(DATA_W - 1));
  assign fall_ok  = scl_fall & ~scl_lvl;
  assign byte_in  = {shreg[DATA_W-2:0], sda_lvl};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      byte_done    <= 1'b0;
      sda_pull_low <= 1'b0;
      tx_req       <= 1'b0;
      rx_valid     <= 1'b0;
      busy         <= 1'b0;
      rx_addr      <= '0;
      rx_rw        <= 1'b0;
      rx_data      <= '0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (start_det) begin
        state        <= ADDR;
        busy         <= 1'b1;
        bit_cnt      <= '0;
        byte_done    <= 1'b0;
        sda_pull_low <= 1'b0;
      end else if (stop_det) begin
        state        <= IDLE;
        busy         <= 1'b0;
        bit_cnt      <= '0;
        byte_done    <= 1'b0;
        sda_pull_low <= 1'b0;
      end else begin
        unique case (state)
          IDLE, IGNORE: ;
          ADDR: begin
            if (scl_rise && !byte_done) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit) begin
                if (shreg[DATA_W-2:0] == SLAVE_ADDR) begin
                  rx_addr   <= shreg[DATA_W-2:0];
                  rx_rw     <= sda_lvl;
                  byte_done <= 1'b1;
                end else begin
                  state <= IGNORE;
                end
              end
            end else if (fall_ok && byte_done) begin
              byte_done    <= 1'b0;
              sda_pull_low <= 1'b1;
              state        <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (fall_ok) begin
              bit_cnt <= '0;
              if (!rx_rw) begin
                sda_pull_low <= 1'b0;
                state        <= WR_DATA;
              end else begin
                shreg        <= tx_data;
                tx_req       <= 1'b1;
                sda_pull_low <= ~tx_data[DATA_W-1];
                state        <= RD_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && !byte_done) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 1'b1;
              if (last_bit) begin
                rx_data   <= byte_in;
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end else if (fall_ok && byte_done) begin
              byte_done    <= 1'b0;
              sda_pull_low <= 1'b1;
              state        <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (fall_ok) begin
              sda_pull_low <= 1'b0;
              bit_cnt      <= '0;
              state        <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (fall_ok) begin
              if (last_bit) begin
                sda_pull_low <= 1'b0;
                bit_cnt      <= '0;
                state        <= RD_ACK;
              end else begin
                shreg        <= {shreg[DATA_W-2:0], 1'b0};
                sda_pull_low <= ~shreg[DATA_W-2];
                bit_cnt      <= bit_cnt + 1'b1;
              end
            end
          end
          RD_ACK: begin
            // master NACK ends the read; ACK reloads on the next fall
            if (scl_rise) begin
              if (sda_lvl) state <= IGNORE;
              else byte_done <= 1'b1;
            end else if (fall_ok && byte_done) begin
              byte_done    <= 1'b0;
              shreg        <= tx_data;
              tx_req       <= 1'b1;
              sda_pull_low <= ~tx_data[DATA_W-1];
              bit_cnt      <= '0;
              state        <= RD_DATA;
            end
          end
        endcase
      end
    end
  end

endmodule
